// File: rtl/cc_io_ctrl.sv
`timescale 1ns/1ps
// cc_io_ctrl: receive-side I/O controller for the Candy Crush core.
// Captures the board, the special-candy records and the actions from the
// stimulus stream. It then hands them to the core with a start/done
// handshake and returns the score as a one-cycle strobe.
module cc_io_ctrl #(
  parameter int N_CELLS = 36,
  parameter int N_SPEC  = 4,
  parameter int N_ACT   = 10,
  parameter int SCORE_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_1,
  input  logic               in_valid_2,
  input  logic [2:0]         in_color,
  input  logic               in_stripe,
  input  logic [1:0]         in_action,
  input  logic [5:0]         in_starting_pos,
  output logic               out_valid,
  output logic [SCORE_W-1:0] out_score,
  output logic               core_start,
  input  logic               core_done,
  input  logic [SCORE_W-1:0] core_score,
  input  logic [5:0]         board_raddr,
  output logic [2:0]         board_rdata,
  input  logic [1:0]         spec_raddr,
  output logic [9:0]         spec_rdata,
  input  logic [3:0]         act_raddr,
  output logic [7:0]         act_rdata,
  output logic               proto_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    GAP   = 3'd2,
    LOAD2 = 3'd3,
    START = 3'd4,
    WAIT  = 3'd5,
    OUT   = 3'd6
  } state_t;

  // Counter values marking a complete board, the end of the special-record
  // beats and a complete action list.
  localparam logic [5:0] BOARD_FULL = 6'(N_CELLS);
  localparam logic [5:0] SPEC_FULL  = 6'(N_SPEC);
  localparam logic [5:0] ACT_FULL   = 6'(N_ACT);

  state_t             r_state;
  state_t             w_stateNext;
  logic [5:0]         r_cnt;
  logic [5:0]         w_cntNext;
  logic               r_protoErr;
  logic               w_errSet;
  logic               w_errClr;
  logic [SCORE_W-1:0] r_score;
  logic               w_scoreWe;
  logic               w_boardWe;
  logic               w_specWe;
  logic               w_actWe;
  logic [5:0]         w_wrIdx;

  logic [2:0] r_board [N_CELLS];
  logic [9:0] r_spec  [N_SPEC];
  logic [7:0] r_act   [N_ACT];

  // Next state, storage write enables, beat counting and error detection.
  // The beat that moves IDLE->LOAD1 or GAP->LOAD2 is itself stored as beat 0.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_wrIdx     = r_cnt;
    w_boardWe   = 1'b0;
    w_specWe    = 1'b0;
    w_actWe     = 1'b0;
    w_errSet    = 1'b0;
    w_errClr    = 1'b0;
    w_scoreWe   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid_1) begin
          w_wrIdx     = 6'd0;
          w_boardWe   = 1'b1;
          w_specWe    = 1'b1;
          w_cntNext   = 6'd1;
          w_errClr    = 1'b1;
          w_errSet    = in_valid_2;
          w_stateNext = LOAD1;
        end
      end
      LOAD1: begin
        if (in_valid_1) begin
          w_errSet = in_valid_2;
          if (r_cnt < BOARD_FULL) begin
            w_boardWe = 1'b1;
            w_specWe  = (r_cnt < SPEC_FULL);
            w_cntNext = r_cnt + 6'd1;
          end else begin
            w_errSet = 1'b1;
          end
        end else begin
          w_errSet    = (r_cnt != BOARD_FULL);
          w_stateNext = GAP;
        end
      end
      GAP: begin
        w_errSet = in_valid_1;
        if (in_valid_2) begin
          w_wrIdx     = 6'd0;
          w_actWe     = 1'b1;
          w_cntNext   = 6'd1;
          w_stateNext = LOAD2;
        end
      end
      LOAD2: begin
        w_errSet = in_valid_1;
        if (in_valid_2) begin
          if (r_cnt < ACT_FULL) begin
            w_actWe   = 1'b1;
            w_cntNext = r_cnt + 6'd1;
          end else begin
            w_errSet = 1'b1;
          end
        end else begin
          if (r_cnt != ACT_FULL) begin
            w_errSet = 1'b1;
          end
          w_stateNext = START;
        end
      end
      START: begin
        w_errSet    = in_valid_1 | in_valid_2;
        w_stateNext = WAIT;
      end
      WAIT: begin
        w_errSet = in_valid_1 | in_valid_2;
        if (core_done) begin
          w_scoreWe   = 1'b1;
          w_stateNext = OUT;
        end
      end
      OUT: begin
        w_errSet    = in_valid_1 | in_valid_2;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Beat counter, sticky protocol error (a set wins over the clear on LOAD1 entry) and captured score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 6'd0;
      r_protoErr <= 1'b0;
      r_score    <= '0;
    end else begin
      r_cnt      <= w_cntNext;
      r_protoErr <= w_errSet | (r_protoErr & ~w_errClr);
      if (w_scoreWe) begin
        r_score <= core_score;
      end
    end
  end

  // Board, special-record and action storage. It has no reset because the contents are meaningless until loaded.
  always_ff @(posedge clk) begin
    if (w_boardWe) begin
      r_board[w_wrIdx] <= in_color;
    end
    if (w_specWe) begin
      r_spec[w_wrIdx[1:0]] <= {in_stripe, in_color, in_starting_pos};
    end
    if (w_actWe) begin
      r_act[w_wrIdx[3:0]] <= {in_action, in_starting_pos};
    end
  end

  assign core_start  = (r_state == START);
  assign out_valid   = (r_state == OUT);
  assign out_score   = out_valid ? r_score : '0;
  assign proto_err   = r_protoErr;
  assign board_rdata = (board_raddr < 6'(N_CELLS)) ? r_board[board_raddr] : 3'd0;
  assign spec_rdata  = r_spec[spec_raddr];
  assign act_rdata   = (act_raddr < 4'(N_ACT)) ? r_act[act_raddr] : 8'd0;

endmodule
